// File: rtl/bus_req_encoder.sv
// bus_req_encoder: 8-way round-robin bus arbiter producing a registered grant index, valid and one-hot select.
// Optional grant watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module bus_req_encoder #(
    parameter int N_REQ       = 8,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] sel,
    output logic             tmo
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First requester at or after last+1, wrapping modulo N_REQ
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = {IDX_W{1'b0}};
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = {N_REQ{1'b0}};
        onehot[idx] = 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] pick_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 6) ? $clog2(TIMEOUT_CYC) : 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    assign pick_s = rr_pick(req, last_q);

    // Next-state and next-output computation for the arbiter FSM
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    vld_d   = 1'b1;
                    idx_d   = pick_s;
                    sel_d   = onehot(pick_s);
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = {CNT_W{1'b0}};
`endif
                end else begin
                    vld_d = 1'b0;
                    sel_d = {N_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                // done has priority over the watchdog, so a same-cycle release is a normal one
                if (done || !req[idx_q]) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    sel_d   = {N_REQ{1'b0}};
                    last_d  = idx_q;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    sel_d   = {N_REQ{1'b0}};
                    last_d  = idx_q;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = ST_GRANT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                sel_d   = {N_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            sel_q   <= {N_REQ{1'b0}};
            last_q  <= {IDX_W{1'b1}};
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= {CNT_W{1'b0}};
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign gnt_vld = vld_q;
    assign gnt_idx = idx_q;
    assign sel     = sel_q;
`ifdef ARB_TIMEOUT_EN
    assign tmo     = tmo_q;
`else
    assign tmo     = 1'b0;
`endif

endmodule
